// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the data RAM (slave).
// One request is held until mem_gnt; read data returns later with mem_rvalid.
interface load_store_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory access at a time, byte-lane placement for stores
// and right-justified lane extraction for loads; extension is left to the execute stage.
module load_store_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_val,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [XLEN-1:0]   load_val,
    load_store_unit_if.master mem
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   tcnt;
    logic [OW-1:0]   off_q;
    logic [1:0]      size_q;
    logic            store_q;

    logic [OW-1:0]   off;
    logic [1:0]      size;
    logic            legal;
    logic            aligned;
    logic [NB-1:0]   be_nxt;
    logic [XLEN-1:0] wdata_nxt;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] ld_nxt;

    // Request decode on the raw inputs; only used in the cycle start is accepted.
    always_comb begin
        off       = addr[OW-1:0];
        size      = funct3[1:0];
        legal     = 1'b0;
        aligned   = 1'b1;
        be_nxt    = '1;
        wdata_nxt = store_val << {off, 3'b000};

        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~is_store;
            default:                legal = 1'b0;
        endcase

        case (size)
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (off == '0);
            default: aligned = 1'b1;
        endcase

        if (is_store) begin
            case (size)
                2'b00:   be_nxt = NB'(1) << off;
                2'b01:   be_nxt = NB'(3) << off;
                default: be_nxt = '1;
            endcase
        end
    end

    always_comb begin
        rshift = mem.mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   ld_nxt = rshift & {{(XLEN-8){1'b0}}, 8'hFF};
            2'b01:   ld_nxt = rshift & {{(XLEN-16){1'b0}}, 16'hFFFF};
            default: ld_nxt = rshift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tcnt          <= '0;
            off_q         <= '0;
            size_q        <= '0;
            store_q       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fault         <= 1'b0;
            load_val      <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (legal && aligned) begin
                            state         <= REQ;
                            tcnt          <= '0;
                            off_q         <= off;
                            size_q        <= size;
                            store_q       <= is_store;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= is_store;
                            mem.mem_addr  <= {addr[XLEN-1:OW], {OW{1'b0}}};
                            mem.mem_be    <= be_nxt;
                            mem.mem_wdata <= wdata_nxt;
                        end else begin
                            // Rejected requests never touch the bus.
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        tcnt        <= '0;
                        if (store_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (tcnt == T_LAST) begin
                        mem.mem_req <= 1'b0;
                        state       <= DONE;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                WAIT: begin
                    if (mem.mem_rvalid) begin
                        load_val <= ld_nxt;
                        state    <= DONE;
                        done     <= 1'b1;
                    end else if (tcnt == T_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        fault <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    tcnt  <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a hand-driven memory slave, expected values
// worked out by hand from the lane rules and cycle timing.
module tb_load_store_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_val;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_val;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned ndone;
    logic        early;

    load_store_unit_if #(.XLEN(32)) mem ();

    load_store_unit #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .store_val (store_val),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .load_val  (load_val),
        .mem       (mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start; returns at the negedge of the first cycle after acceptance.
    task automatic go(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sv);
        start     = 1'b1;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        store_val = sv;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        is_store = 1'b0;
        funct3 = 3'b000;
        addr = '0;
        store_val = '0;
        mem.mem_gnt = 1'b0;
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata = '0;
        repeat (2) @(negedge clk);

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_load_val", load_val, 0);
        chk("rst_req", mem.mem_req, 0);
        chk("rst_we", mem.mem_we, 0);
        chk("rst_addr", mem.mem_addr, 0);
        chk("rst_be", mem.mem_be, 0);
        chk("rst_wdata", mem.mem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW 0x100: REQ, WAIT, DONE in cycles 1..3
        go(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_req", mem.mem_req, 1);
        chk("lw_we", mem.mem_we, 0);
        chk("lw_addr", mem.mem_addr, 32'h100);
        chk("lw_be", mem.mem_be, 32'hF);
        chk("lw_busy", busy, 1);
        chk("lw_done_c1", done, 0);
        mem.mem_gnt = 1'b1;
        @(negedge clk);
        mem.mem_gnt = 1'b0;
        chk("lw_req_wait", mem.mem_req, 0);
        chk("lw_done_c2", done, 0);
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem.mem_rvalid = 1'b0;
        chk("lw_done_c3", done, 1);
        chk("lw_fault", fault, 0);
        chk("lw_load_val", load_val, 32'hDEADBEEF);
        chk("lw_busy_done", busy, 1);
        @(negedge clk);
        chk("lw_done_c4", done, 0);
        chk("lw_busy_c4", busy, 0);

        // SB 0x103: lane 3
        go(1'b1, 3'b000, 32'h103, 32'h123456A5);
        chk("sb_req", mem.mem_req, 1);
        chk("sb_we", mem.mem_we, 1);
        chk("sb_addr", mem.mem_addr, 32'h100);
        chk("sb_be", mem.mem_be, 32'h8);
        chk("sb_wdata", mem.mem_wdata, 32'hA5000000);
        mem.mem_gnt = 1'b1;
        @(negedge clk);
        mem.mem_gnt = 1'b0;
        chk("sb_done", done, 1);
        chk("sb_fault", fault, 0);
        chk("sb_load_val_kept", load_val, 32'hDEADBEEF);
        @(negedge clk);

        // LH 0x102: upper half
        go(1'b0, 3'b001, 32'h102, 32'h0);
        mem.mem_gnt = 1'b1;
        @(negedge clk);
        mem.mem_gnt = 1'b0;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata = 32'h8001FFFF;
        @(negedge clk);
        mem.mem_rvalid = 1'b0;
        chk("lh_done", done, 1);
        chk("lh_load_val", load_val, 32'h00008001);
        @(negedge clk);

        // Misaligned LH and illegal store funct3 fault immediately
        go(1'b0, 3'b001, 32'h101, 32'h0);
        chk("lh_mis_done", done, 1);
        chk("lh_mis_fault", fault, 1);
        chk("lh_mis_req", mem.mem_req, 0);
        chk("lh_mis_load_val", load_val, 32'h00008001);
        @(negedge clk);
        chk("lh_mis_after", done, 0);
        go(1'b1, 3'b100, 32'h0, 32'h0);
        chk("ill_done", done, 1);
        chk("ill_fault", fault, 1);
        @(negedge clk);

        // Grant withheld: stable bus, then timeout after TIMEOUT REQ cycles
        go(1'b0, 3'b010, 32'h40, 32'h0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk("hold_req", mem.mem_req, 1);
            chk("hold_addr", mem.mem_addr, 32'h40);
            chk("hold_be", mem.mem_be, 32'hF);
        end
        early = 1'b0;
        for (int c = 5; c <= 16; c++) begin
            @(negedge clk);
            if (done) early = 1'b1;
        end
        chk("to_no_early_done", early, 0);
        @(negedge clk);
        chk("to_done", done, 1);
        chk("to_fault", fault, 1);
        chk("to_req", mem.mem_req, 0);
        mem.mem_gnt = 1'b1;
        @(negedge clk);
        mem.mem_gnt = 1'b0;
        chk("to_idle_done", done, 0);
        chk("to_idle_busy", busy, 0);
        chk("to_idle_req", mem.mem_req, 0);

        // Reset while in WAIT
        go(1'b0, 3'b010, 32'h300, 32'h0);
        mem.mem_gnt = 1'b1;
        @(negedge clk);
        mem.mem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_load_val", load_val, 0);
        chk("mid_rst_addr", mem.mem_addr, 0);
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata = 32'h11111111;
        @(negedge clk);
        mem.mem_rvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_load_val", load_val, 0);

        go(1'b1, 3'b010, 32'h200, 32'hCAFEF00D);
        chk("sw_addr", mem.mem_addr, 32'h200);
        chk("sw_be", mem.mem_be, 32'hF);
        chk("sw_wdata", mem.mem_wdata, 32'hCAFEF00D);
        chk("sw_we", mem.mem_we, 1);
        mem.mem_gnt = 1'b1;
        @(negedge clk);
        mem.mem_gnt = 1'b0;
        chk("sw_done", done, 1);
        chk("sw_fault", fault, 0);
        @(negedge clk);

        // start repeated while busy and in DONE must be ignored
        ndone = 0;
        go(1'b1, 3'b000, 32'h201, 32'h00000055);
        chk("sb1_be", mem.mem_be, 32'h2);
        chk("sb1_wdata", mem.mem_wdata, 32'h00005500);
        start = 1'b1;
        addr = 32'h0;
        funct3 = 3'b001;
        @(negedge clk);
        mem.mem_gnt = 1'b1;
        chk("busy_start_addr", mem.mem_addr, 32'h200);
        @(negedge clk);
        mem.mem_gnt = 1'b0;
        if (done) ndone++;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("one_done_per_start", ndone, 1);
        chk("final_busy", busy, 0);
        chk("final_req", mem.mem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
